// File: rtl/addsub_pkg.sv
// Shared opcodes, FSM encoding and hold-pattern constants
// for the add/sub datapath command sequencer.
package addsub_pkg;

   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_SUB     = 2'b01;
   localparam logic [1:0] OP_ACC_ADD = 2'b10;
   localparam logic [1:0] OP_ACC_SUB = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_STEP,
      ST_DONE
   } state_t;

   localparam logic HOLD_SEL    = 1'b1;
   localparam logic HOLD_ADDSUB = 1'b0;
   localparam logic HOLD_FILL   = 1'b0;

   // Only the first iteration of ADD/SUB loads A; everything else feeds back Z.
   function automatic logic issue_sel(input logic first,
                                      input logic [1:0] op);
      return !(first && !op[1]);
   endfunction

endpackage

// File: rtl/addsub_seq_timer.sv
// Loadable down-counter pacing the datapath latency wait.
// expire is high on the last cycle of the wait.
module addsub_seq_timer #(
   parameter int W = 2
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         expire
);

   logic [W-1:0] count;

   always_ff @(posedge Clock) begin
      if (Reset)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (dec && count != '0)
         count <= count - W'(1);
   end

   assign expire = (count <= W'(1));

endmodule

// File: rtl/addsub_sequencer.sv
// Command sequencer for the registered add/sub datapath.
// Define ADDSUB_SEQUENCER_STATS_EN to add response/overflow counters.
module addsub_sequencer
   import addsub_pkg::*;
#(
   parameter int N   = 16,
   parameter int RW  = 4,
   parameter int LAT = 2
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [N-1:0]  cmd_a,
   input  logic [N-1:0]  cmd_b,
   input  logic [RW-1:0] cmd_rep,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [N-1:0]  rsp_z,
   output logic          rsp_ovf,
   output logic [N-1:0]  dp_A,
   output logic [N-1:0]  dp_B,
   output logic          dp_Sel,
   output logic          dp_AddSub,
   input  logic [N-1:0]  dp_Z,
   input  logic          dp_Overflow,
`ifdef ADDSUB_SEQUENCER_STATS_EN
   output logic [15:0]   stat_cmds,
   output logic [15:0]   stat_ovf,
`endif
   output logic          busy
);

   localparam int TW = $clog2(LAT + 1);

   state_t        state;
   logic [1:0]    op_q;
   logic [N-1:0]  a_q;
   logic [N-1:0]  b_q;
   logic [RW-1:0] iters_left;
   logic          sticky_ovf;
   logic          accept;
   logic          wait_done;

   assign cmd_ready = (state == ST_IDLE) ||
                      (state == ST_DONE && rsp_ready);
   assign accept    = cmd_valid && cmd_ready;
   assign rsp_valid = (state == ST_DONE);
   assign busy      = (state != ST_IDLE);

   addsub_seq_timer #(.W(TW)) u_timer (
      .Clock    (Clock),
      .Reset    (Reset),
      .load     (state == ST_ISSUE),
      .load_val (TW'(LAT - 1)),
      .dec      (state == ST_WAIT),
      .expire   (wait_done)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state      <= ST_IDLE;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         iters_left <= '0;
         sticky_ovf <= 1'b0;
         rsp_z      <= '0;
         rsp_ovf    <= 1'b0;
         dp_A       <= '0;
         dp_B       <= '0;
         dp_Sel     <= 1'b0;
         dp_AddSub  <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  op_q       <= cmd_op;
                  a_q        <= cmd_a;
                  b_q        <= cmd_b;
                  iters_left <= cmd_rep;
                  sticky_ovf <= 1'b0;
                  dp_A       <= cmd_a;
                  dp_B       <= cmd_b;
                  dp_AddSub  <= cmd_op[0];
                  dp_Sel     <= issue_sel(1'b1, cmd_op);
                  state      <= ST_ISSUE;
               end else if (state == ST_DONE && rsp_ready) begin
                  state <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               dp_A      <= {N{HOLD_FILL}};
               dp_B      <= {N{HOLD_FILL}};
               dp_Sel    <= HOLD_SEL;
               dp_AddSub <= HOLD_ADDSUB;
               state     <= ST_WAIT;
            end
            ST_WAIT: begin
               if (wait_done)
                  state <= ST_STEP;
            end
            ST_STEP: begin
               sticky_ovf <= sticky_ovf | dp_Overflow;
               if (iters_left == '0) begin
                  rsp_z   <= dp_Z;
                  rsp_ovf <= sticky_ovf | dp_Overflow;
                  state   <= ST_DONE;
               end else begin
                  iters_left <= iters_left - RW'(1);
                  dp_A       <= a_q;
                  dp_B       <= b_q;
                  dp_AddSub  <= op_q[0];
                  dp_Sel     <= issue_sel(1'b0, op_q);
                  state      <= ST_ISSUE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef ADDSUB_SEQUENCER_STATS_EN
   logic rsp_hs;
   assign rsp_hs = rsp_valid && rsp_ready;

   // Saturating so a long soak never wraps back to a small count.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         stat_cmds <= '0;
         stat_ovf  <= '0;
      end else if (rsp_hs) begin
         if (stat_cmds != 16'hFFFF)
            stat_cmds <= stat_cmds + 16'd1;
         if (rsp_ovf && stat_ovf != 16'hFFFF)
            stat_ovf <= stat_ovf + 16'd1;
      end
   end
`endif

endmodule
